// File: rtl/wishbone_pkg.sv
// rtl/wishbone_pkg.sv - shared Wishbone widths, arbiter state type and defaults
//
// Purpose: common constants and types for the Wishbone arbiter slice.
// Ports:   none (package).
package wishbone_pkg;

   localparam int WB_ADDR_W          = 24;
   localparam int WB_DATA_W          = 16;
   localparam int WB_TIMEOUT_DEFAULT = 255;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_t;

   // Index width for a master count; one bit minimum so a lone master still has a register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin first-set search
//
// Purpose: pick the first set request bit after the previous winner, wrapping modulo N.
// Ports:
//   req    in  N      request vector
//   last   in  IDX_W  index of the previous winner
//   valid  out 1      at least one request is set
//   idx    out IDX_W  chosen index (0 when valid is low)
module rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   int               cand_full;
   logic [IDX_W-1:0] cand;

   always_comb begin
      valid     = 1'b0;
      idx       = '0;
      cand_full = 0;
      cand      = '0;
      // Scan starts one past the previous winner, so that winner is considered last.
      for (int k = 1; k <= N; k++) begin
         cand_full = (int'(last) + k) % N;
         cand      = cand_full[IDX_W-1:0];
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// rtl/wishbone_arbiter.sv - round-robin Wishbone classic arbiter with strobe watchdog
//
// Purpose: share one Wishbone slave between N_MASTERS masters, one grant per cyc envelope,
//          with a watchdog that error-terminates strobes the slave never acknowledges.
// Ports:
//   clk, rstN                      clock, asynchronous active-low reset
//   mCycI/mStbI/mWeI   in  N       per-master cycle, strobe, write enable
//   mAdrI              in  N*ADDR_W per-master address, master i at [i*ADDR_W +: ADDR_W]
//   mDatI              in  N*DATA_W per-master write data, same packing
//   mDatO              out DATA_W  read data broadcast to all masters
//   mAckO/mErrO        out N       per-master acknowledge / timeout error
//   sCycO/sStbO/sWeO   out 1       slave controls
//   sAdrO/sDatO        out         slave address / write data
//   sDatI/sAckI        in          slave read data / acknowledge
module wishbone_arbiter
   import wishbone_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = WB_ADDR_W,
   parameter int DATA_W    = WB_DATA_W,
   parameter int TIMEOUT   = WB_TIMEOUT_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic [N_MASTERS-1:0]          mCycI,
   input  logic [N_MASTERS-1:0]          mStbI,
   input  logic [N_MASTERS-1:0]          mWeI,
   input  logic [N_MASTERS*ADDR_W-1:0]   mAdrI,
   input  logic [N_MASTERS*DATA_W-1:0]   mDatI,
   output logic [DATA_W-1:0]             mDatO,
   output logic [N_MASTERS-1:0]          mAckO,
   output logic [N_MASTERS-1:0]          mErrO,
   output logic                          sCycO,
   output logic                          sStbO,
   output logic                          sWeO,
   output logic [ADDR_W-1:0]             sAdrO,
   output logic [DATA_W-1:0]             sDatO,
   input  logic [DATA_W-1:0]             sDatI,
   input  logic                          sAckI
);

   localparam int               IDX_W      = idx_width(N_MASTERS);
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_MASTERS - 1);
   localparam logic [15:0]      WD_LAST    = 16'(TIMEOUT - 1);

   arb_state_t             state, state_nxt;
   logic [IDX_W-1:0]       owner, owner_nxt;
   logic [IDX_W-1:0]       lastOwner, last_owner_nxt;
   logic [15:0]            wdCnt, wd_cnt_nxt;
   logic [N_MASTERS-1:0]   err_nxt;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;

   rr_picker #(
      .N     (N_MASTERS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req   (mCycI),
      .last  (lastOwner),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign mDatO = sDatI;

   // Slave-side mux and ack routing; everything is zero outside a grant so an async
   // reset drops the bus in the same instant.
   always_comb begin
      sCycO = 1'b0;
      sStbO = 1'b0;
      sWeO  = 1'b0;
      sAdrO = '0;
      sDatO = '0;
      mAckO = '0;
      if (state == GRANTED) begin
         sCycO = mCycI[owner];
         // Strobe is withheld during the error cycle so the slave sees the transfer end.
         sStbO = mStbI[owner] & ~mErrO[owner];
         sWeO  = mWeI[owner];
         sAdrO = mAdrI[int'(owner)*ADDR_W +: ADDR_W];
         sDatO = mDatI[int'(owner)*DATA_W +: DATA_W];
         mAckO[owner] = sAckI & sStbO;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = lastOwner;
      wd_cnt_nxt     = wdCnt;
      err_nxt        = '0;
      case (state)
         IDLE: begin
            wd_cnt_nxt = '0;
            if (pick_valid) begin
               owner_nxt = pick_idx;
               state_nxt = GRANTED;
            end
         end
         GRANTED: begin
            if (!mCycI[owner]) begin
               last_owner_nxt = owner;
               wd_cnt_nxt     = '0;
               state_nxt      = IDLE;
            end else if (sAckI || !sStbO) begin
               // An ack arriving on the expiry cycle wins over the timeout.
               wd_cnt_nxt = '0;
            end else if (wdCnt == WD_LAST) begin
               err_nxt[owner] = 1'b1;
               wd_cnt_nxt     = '0;
            end else begin
               wd_cnt_nxt = wdCnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         owner     <= '0;
         lastOwner <= LAST_RESET;
         wdCnt     <= '0;
         mErrO     <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         lastOwner <= last_owner_nxt;
         wdCnt     <= wd_cnt_nxt;
         mErrO     <= err_nxt;
      end
   end

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Round-robin arbiter sharing one Wishbone classic slave bus (24-bit address, 16-bit data) between up to N masters, e.g. the Modbus-to-Wishbone bridge and a local debug/config master. The arbiter grants the slave to one master per bus cycle (`cyc` envelope), muxes that master's signals onto the slave, and routes `ack`/data back. A per-strobe watchdog terminates transfers the slave never acknowledges, so a dead address cannot lock the bus. It sits between the masters and the register/data slave in the system clock domain.

## Interface
- `N_MASTERS`, 2, number of requesting masters (2..8)
- `ADDR_W`, 24, Wishbone address width
- `DATA_W`, 16, Wishbone data width
- `TIMEOUT`, 255, cycles of unacknowledged strobe before error termination (1..65535)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rstN`  in  1  reset, asynchronous, active-low
- `mCycI`  in  N_MASTERS  per-master cycle request
- `mStbI`  in  N_MASTERS  per-master strobe
- `mWeI`  in  N_MASTERS  per-master write enable
- `mAdrI`  in  N_MASTERS*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W]
- `mDatI`  in  N_MASTERS*DATA_W  per-master write data, same packing
- `mDatO`  out  DATA_W  read data, broadcast to all masters
- `mAckO`  out  N_MASTERS  per-master acknowledge
- `mErrO`  out  N_MASTERS  per-master timeout error
- `sCycO`, `sStbO`, `sWeO`  out  1  slave-side controls
- `sAdrO`  out  ADDR_W  slave address
- `sDatO`  out  DATA_W  slave write data
- `sDatI`  in  DATA_W  slave read data
- `sAckI`  in  1  slave acknowledge

## Operation
- State register: `IDLE`, `GRANTED`; registers `owner` (index), `lastOwner` (index), `wdCnt` (16 bit).
- Reset values: state `IDLE`, `owner` 0, `lastOwner` N_MASTERS-1, `wdCnt` 0, `mErrO` 0. All combinational outputs reset-consistent: `sCycO`/`sStbO`/`sWeO` 0, `sAdrO`/`sDatO` 0, `mAckO` 0.
- `IDLE`: if any `mCycI` set, pick first set bit searching `lastOwner+1, lastOwner+2, …` with wrap modulo N_MASTERS; load `owner`, go `GRANTED`. No request -> stay.
- `GRANTED`: `sCycO = mCycI[owner]`, `sStbO = mStbI[owner] & ~mErrO[owner]`, `sWeO`/`sAdrO`/`sDatO` = owner's fields (combinational mux from `owner`). `mAckO[owner] = sAckI & sStbO`; other `mAckO` bits 0. `mDatO = sDatI` always.
- Release: `mCycI[owner]` low -> `lastOwner <= owner`, go `IDLE`. Grant is held across any number of strobes while `cyc` stays high (locked sequences allowed).
- Watchdog: `wdCnt` increments each cycle `sStbO & ~sAckI`; clears on `sAckI` or `~sStbO`. When `wdCnt == TIMEOUT-1` and no ack: `mErrO[owner] <= 1` for exactly one cycle, `wdCnt <= 0`; `sStbO` masked during that cycle. Owner keeps grant; it must drop `stb` or retry.
- Ack and timeout same cycle: ack wins, no error.
- Non-owner `stb`/`cyc` ignored; never reaches slave.

## Timing
- Grant latency: `mCycI` rising in `IDLE` -> `sCycO` high the next cycle (1 clk).
- Slave signals are combinational from `owner` and owner inputs: zero added latency within grant.
- Release: `cyc` low at edge k -> `IDLE` at k+1 -> next owner's `sCycO` at k+2. Minimum one idle cycle between grants.
- Error: `mErrO` high in cycle TIMEOUT+1 after strobe start (registered), one cycle wide.
- Asynchronous `rstN` low mid-transfer: slave controls drop immediately (combinational from reset state); no ack or error delivered for the aborted transfer.

## Structure
- Package `wishbone_pkg`: `WB_ADDR_W` = 24, `WB_DATA_W` = 16, arbiter state enum, default TIMEOUT constant.
- Sub-module `rr_picker`: combinational round-robin first-set search (request vector, `lastOwner`) -> (`valid`, index). Reusable by future arbiters.

## Test plan
- Single master 0 reads 0xA00005 (slave holds i*3): `mAckO[0]` pulses, `mDatO` = 0x000F; `mAckO[1]` stays 0.
- Both masters raise `cyc` same cycle after reset -> master 0 granted first; after its release master 1 granted with one idle cycle; repeat -> alternates 0,1,0,1.
- Master 0 holds `cyc` over 4 strobes to 0xA00000..03 while master 1 requests -> master 1 waits until master 0 drops `cyc`.
- Strobe to address with ack suppressed, TIMEOUT=8 -> `mErrO[owner]` one-cycle pulse 9 cycles after strobe, `sStbO` low that cycle, grant retained.
- Write 0x1234 to 0xA00010 by master 1, then read by master 0 -> read returns 0x1234.
- `rstN` asserted mid-strobe -> `sCycO`/`sStbO` 0 immediately, state `IDLE`, next arbitration starts from master 0.
